// File: rtl/dsa_pkg.sv
// Shared types and constants for the DSA output-side pixel packer.
package dsa_pkg;

    localparam int BPW          = 4;
    localparam int DSA_OUT_BASE = 16384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_PAUSE,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } pack_state_e;

endpackage

// File: rtl/dsa_step_gate.sv
// Step-mode release for the packer: registered rising-edge detect on the
// "next" button, or immediate release once step mode is switched off.
module dsa_step_gate (
    input  logic clk,
    input  logic rst_n,
    input  logic i_step_mode,
    input  logic i_step_trig,
    output logic o_release
);

    logic trig_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            trig_q <= i_step_trig;
            rise_q <= i_step_trig & ~trig_q;
        end
    end

    // A held button produces a single pulse on rise_q.
    assign o_release = rise_q | ~i_step_mode;

endmodule

// File: rtl/dsa_pixel_packer.sv
// Packs 1..MAX_LANES pixels per beat into DATA_W-bit memory words with an optional
// per-write step pause. Statistics counters exist only with DSA_PACK_STATS_EN.
module dsa_pixel_packer
    import dsa_pkg::*;
#(
    parameter int DATA_W    = BPW * 8,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 16,
    parameter int MAX_LANES = 4,
    parameter int CNT_W     = 18
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic [ADDR_W-1:0]                i_base_addr,
    input  logic [CNT_W-1:0]                 i_total_pix,
    input  logic                             i_pix_valid,
    output logic                             o_pix_ready,
    input  logic [MAX_LANES*PIX_W-1:0]       i_pix_data,
    input  logic [$clog2(MAX_LANES+1)-1:0]   i_pix_count,
    input  logic                             i_step_mode,
    input  logic                             i_step_trig,
    output logic [ADDR_W-1:0]                o_mem_addr,
    output logic                             o_mem_we,
    output logic [DATA_W/PIX_W-1:0]          o_mem_byte_en,
    output logic [DATA_W-1:0]                o_mem_wdata,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [CNT_W-1:0]                 o_words_written,
    output logic [CNT_W-1:0]                 o_pix_dropped
);

    localparam int WORD_BYTES  = DATA_W / PIX_W;
    localparam int STAGE_BYTES = 2 * WORD_BYTES;
    localparam int FILL_W      = $clog2(STAGE_BYTES + 1);

    // Beat handshake: a beat transfers on a rising clk edge where
    // i_pix_valid && o_pix_ready; o_pix_ready depends only on registered state.
    pack_state_e       state, state_n, target, target_n, route;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  remaining, lane_cnt, take, eval_rem;
    logic [FILL_W-1:0] fill, eval_fill;
    logic [PIX_W-1:0]  stage [STAGE_BYTES];
    logic              handshake, evaluate, step_release;

    dsa_step_gate u_step_gate (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_step_mode (i_step_mode),
        .i_step_trig (i_step_trig),
        .o_release   (step_release)
    );

    always_comb begin
        lane_cnt = CNT_W'(i_pix_count);
        if (i_pix_count == '0 || int'(i_pix_count) > MAX_LANES) begin
            lane_cnt = CNT_W'(MAX_LANES);
        end
        take = (lane_cnt < remaining) ? lane_cnt : remaining;
    end

    assign o_pix_ready = (state == ST_ACCEPT) && (fill < FILL_W'(WORD_BYTES)) && (remaining != '0);
    assign handshake   = o_pix_ready && i_pix_valid;

    // ACCEPT and WRITE share one routing rule applied to the post-edge fill/remaining.
    always_comb begin
        state_n   = state;
        target_n  = target;
        evaluate  = 1'b0;
        eval_fill = fill;
        eval_rem  = remaining;
        route     = ST_ACCEPT;
        case (state)
            ST_IDLE:   if (i_start) state_n = (i_total_pix == '0) ? ST_DONE : ST_ACCEPT;
            ST_ACCEPT: begin
                evaluate = 1'b1;
                if (handshake) begin
                    eval_fill = fill + FILL_W'(take);
                    eval_rem  = remaining - take;
                end
            end
            ST_WRITE: begin
                evaluate  = 1'b1;
                eval_fill = fill - FILL_W'(WORD_BYTES);
            end
            ST_PAUSE:  if (step_release) state_n = target;
            ST_FLUSH:  state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        if (evaluate) begin
            if (eval_fill >= FILL_W'(WORD_BYTES))   route = ST_WRITE;
            else if (eval_rem == '0 && eval_fill != '0) route = ST_FLUSH;
            else if (eval_rem == '0)                route = ST_DONE;
            if (i_step_mode && (route == ST_WRITE || route == ST_FLUSH)) begin
                state_n  = ST_PAUSE;
                target_n = route;
            end else begin
                state_n = route;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            target    <= ST_WRITE;
            wr_addr   <= '0;
            remaining <= '0;
            fill      <= '0;
            for (int j = 0; j < STAGE_BYTES; j++) stage[j] <= '0;
        end else begin
            state  <= state_n;
            target <= target_n;
            case (state)
                ST_IDLE: if (i_start) begin
                    wr_addr   <= i_base_addr;
                    remaining <= i_total_pix;
                    fill      <= '0;
                    for (int j = 0; j < STAGE_BYTES; j++) stage[j] <= '0;
                end
                ST_ACCEPT: if (handshake) begin
                    for (int j = 0; j < STAGE_BYTES; j++) begin
                        for (int i = 0; i < MAX_LANES; i++) begin
                            if (CNT_W'(i) < take && int'(fill) + i == j) begin
                                stage[j] <= i_pix_data[i*PIX_W +: PIX_W];
                            end
                        end
                    end
                    fill      <= fill + FILL_W'(take);
                    remaining <= remaining - take;
                end
                ST_WRITE: begin
                    for (int j = 0; j < WORD_BYTES; j++) begin
                        stage[j]              <= stage[j+WORD_BYTES];
                        stage[j+WORD_BYTES]   <= '0;
                    end
                    fill    <= fill - FILL_W'(WORD_BYTES);
                    wr_addr <= wr_addr + 1'b1;
                end
                ST_FLUSH: begin
                    for (int j = 0; j < STAGE_BYTES; j++) stage[j] <= '0;
                    fill    <= '0;
                    wr_addr <= wr_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory port decoded purely from registered state; flush masks bytes at or above fill.
    always_comb begin
        o_mem_byte_en = '0;
        o_mem_wdata   = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (state == ST_WRITE || (state == ST_FLUSH && FILL_W'(b) < fill)) begin
                o_mem_byte_en[b]               = 1'b1;
                o_mem_wdata[b*PIX_W +: PIX_W] = stage[b];
            end
        end
    end

    assign o_mem_we   = (state == ST_WRITE) || (state == ST_FLUSH);
    assign o_mem_addr = wr_addr;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);

`ifdef DSA_PACK_STATS_EN
    logic [CNT_W-1:0] words_q;
    logic [CNT_W-1:0] dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q   <= '0;
            dropped_q <= '0;
        end else if (state == ST_IDLE && i_start) begin
            words_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (o_mem_we) words_q <= words_q + 1'b1;
            if (handshake) dropped_q <= dropped_q + (lane_cnt - take);
        end
    end

    assign o_words_written = words_q;
    assign o_pix_dropped   = dropped_q;
`else
    assign o_words_written = '0;
    assign o_pix_dropped   = '0;
`endif

endmodule
